// File: rtl/game_flow_ctrl.sv
// Game-flow controller: tracks level/world/lives and sequences play, pause, level-up, world-up,
// death/invulnerability, win and lose screens. Outputs are registered copies of the decoded next state.
module game_flow_ctrl #(
  parameter int LEVEL_MAX   = 3,
  parameter int WORLD_MAX   = 6,
  parameter int START_LIVES = 7,
  parameter int MAX_LIVES   = 9,
  parameter int LVL_W       = 3,
  parameter int WLD_W       = 3,
  parameter int LIVES_W     = 5,
  parameter int INVULN_CYC  = 16,
  parameter int BONUS_EVERY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               continue_btn,
  input  logic               start_btn,
  input  logic               player_dead,
  input  logic               level_complete,
  output logic [LVL_W-1:0]   level,
  output logic [WLD_W-1:0]   world,
  output logic [LIVES_W-1:0] lives,
  output logic [2:0]         screen,
  output logic               player_disable,
  output logic               reset_select,
  output logic [3:0]         audio_select,
  output logic               invuln
);

  localparam int TMR_W = (INVULN_CYC > 1) ? $clog2(INVULN_CYC) : 1;
  localparam int BON_W = (BONUS_EVERY > 1) ? $clog2(BONUS_EVERY + 1) : 1;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_PLAY   = 4'd1,
    S_PAUSE  = 4'd2,
    S_LVL_UP = 4'd3,
    S_WLD_UP = 4'd4,
    S_DEATH  = 4'd5,
    S_INVULN = 4'd6,
    S_WIN    = 4'd7,
    S_LOSE   = 4'd8,
    S_RESET  = 4'd9
  } state_t;

  typedef struct packed {
    logic [2:0] screen;
    logic       player_disable;
    logic       reset_select;
    logic [3:0] audio;
    logic       invuln;
  } outs_t;

  function automatic outs_t decode(input state_t s);
    outs_t o;
    o = '{screen: 3'd0, player_disable: 1'b1, reset_select: 1'b0, audio: 4'd7, invuln: 1'b0};
    case (s)
      S_INIT:   o.screen = 3'd1;
      S_PLAY:   begin o.screen = 3'd1; o.player_disable = 1'b0; end
      S_PAUSE:  begin o.screen = 3'd6; o.audio = 4'd0; end
      S_LVL_UP: begin o.screen = 3'd4; o.audio = 4'd2; end
      S_WLD_UP: begin o.screen = 3'd5; o.audio = 4'd3; end
      S_DEATH:  o.audio = 4'd1;
      S_INVULN: begin o.player_disable = 1'b0; o.invuln = 1'b1; o.audio = 4'd1; end
      S_WIN:    begin o.screen = 3'd3; o.audio = 4'd4; end
      S_LOSE:   begin o.screen = 3'd2; o.audio = 4'd5; end
      S_RESET:  o.reset_select = 1'b1;
      default:  ;
    endcase
    return o;
  endfunction

  state_t             state, state_next;
  logic [LVL_W-1:0]   level_next;
  logic [WLD_W-1:0]   world_next;
  logic [LIVES_W-1:0] lives_next;
  logic [TMR_W-1:0]   timer, timer_next;
  logic [BON_W-1:0]   bonus_cnt, bonus_next;
  logic               cont_prev, start_prev;
  outs_t              outs;

  wire cont_e  = continue_btn & ~cont_prev;
  wire pause_e = start_btn & ~start_prev;

  always_comb begin
    // NOTE: every next-value gets a default first so no path leaves it unassigned and no latch is inferred.
    state_next = state;
    level_next = level;
    world_next = world;
    lives_next = lives;
    timer_next = timer;
    bonus_next = bonus_cnt;
    case (state)
      S_INIT: if (cont_e) state_next = S_PLAY;
      S_PLAY: begin
        if (player_dead) begin
          state_next = S_DEATH;
        end else if (level_complete) begin
          if (level < LVL_W'(LEVEL_MAX)) begin
            level_next = level + LVL_W'(1);
            state_next = S_LVL_UP;
          end else if (world < WLD_W'(WORLD_MAX)) begin
            world_next = world + WLD_W'(1);
            level_next = LVL_W'(1);
            state_next = S_WLD_UP;
            if (BONUS_EVERY != 0) begin
              // The world just cleared completes a bonus group when the count wraps.
              if (bonus_cnt == BON_W'((BONUS_EVERY > 0) ? BONUS_EVERY - 1 : 0)) begin
                bonus_next = '0;
                if (lives < LIVES_W'(MAX_LIVES)) lives_next = lives + LIVES_W'(1);
              end else begin
                bonus_next = bonus_cnt + BON_W'(1);
              end
            end
          end else begin
            state_next = S_WIN;
          end
        end else if (pause_e) begin
          state_next = S_PAUSE;
        end
      end
      S_PAUSE:  if (pause_e) state_next = S_PLAY;
      S_LVL_UP: if (cont_e) state_next = S_PLAY;
      S_WLD_UP: if (cont_e) state_next = S_PLAY;
      S_DEATH: begin
        if (lives <= LIVES_W'(1)) begin
          lives_next = '0;
          state_next = S_LOSE;
        end else begin
          lives_next = lives - LIVES_W'(1);
          timer_next = TMR_W'(INVULN_CYC - 1);
          state_next = S_INVULN;
        end
      end
      S_INVULN: begin
        if (timer != '0)      timer_next = timer - TMR_W'(1);
        else if (!player_dead) state_next = S_PLAY;
      end
      S_WIN:  if (cont_e) state_next = S_RESET;
      S_LOSE: if (cont_e) state_next = S_RESET;
      S_RESET: begin
        level_next = LVL_W'(1);
        world_next = WLD_W'(1);
        lives_next = LIVES_W'(START_LIVES);
        timer_next = '0;
        bonus_next = '0;
        state_next = S_INIT;
      end
      default: state_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values and updates together.
    if (rst) begin
      state      <= S_INIT;
      level      <= LVL_W'(1);
      world      <= WLD_W'(1);
      lives      <= LIVES_W'(START_LIVES);
      timer      <= '0;
      bonus_cnt  <= '0;
      cont_prev  <= 1'b0;
      start_prev <= 1'b0;
      outs       <= decode(S_INIT);
    end else begin
      state      <= state_next;
      level      <= level_next;
      world      <= world_next;
      lives      <= lives_next;
      timer      <= timer_next;
      bonus_cnt  <= bonus_next;
      cont_prev  <= continue_btn;
      start_prev <= start_btn;
      outs       <= decode(state_next);
    end
  end

  assign screen         = outs.screen;
  assign player_disable = outs.player_disable;
  assign reset_select   = outs.reset_select;
  assign audio_select   = outs.audio;
  assign invuln         = outs.invuln;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus randomized play, compared each
// cycle against a behavioural game model; a second instance covers bonus-life saturation.
module tb_game_flow_ctrl;

  localparam int LMAX = 3, WMAX = 6, SLIVES = 7, MLIVES = 9, INV = 16, BEV = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic cont_btn = 1'b0, start_btn = 1'b0, dead = 1'b0, lc = 1'b0;
  logic [2:0] level, world, d2_level, d2_world;
  logic [4:0] lives, d2_lives;
  logic [2:0] screen, d2_screen;
  logic       player_disable, reset_select, invuln;
  logic       d2_player_disable, d2_reset_select, d2_invuln;
  logic [3:0] audio_select, d2_audio_select;

  always #5 clk = ~clk;

  game_flow_ctrl #(.LEVEL_MAX(LMAX), .WORLD_MAX(WMAX), .START_LIVES(SLIVES), .MAX_LIVES(MLIVES),
                   .LVL_W(3), .WLD_W(3), .LIVES_W(5), .INVULN_CYC(INV), .BONUS_EVERY(BEV)) dut (
    .clk(clk), .rst(rst), .continue_btn(cont_btn), .start_btn(start_btn), .player_dead(dead),
    .level_complete(lc), .level(level), .world(world), .lives(lives), .screen(screen),
    .player_disable(player_disable), .reset_select(reset_select), .audio_select(audio_select),
    .invuln(invuln));

  // Starts one below the ceiling with a bonus every world, so two world clears must saturate.
  game_flow_ctrl #(.LEVEL_MAX(LMAX), .WORLD_MAX(WMAX), .START_LIVES(8), .MAX_LIVES(MLIVES),
                   .LVL_W(3), .WLD_W(3), .LIVES_W(5), .INVULN_CYC(INV), .BONUS_EVERY(1)) dut2 (
    .clk(clk), .rst(rst), .continue_btn(cont_btn), .start_btn(start_btn), .player_dead(dead),
    .level_complete(lc), .level(d2_level), .world(d2_world), .lives(d2_lives), .screen(d2_screen),
    .player_disable(d2_player_disable), .reset_select(d2_reset_select),
    .audio_select(d2_audio_select), .invuln(d2_invuln));

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural game model: a mode number plus plain integer counters.
  localparam int M_INIT = 0, M_PLAY = 1, M_PAUSE = 2, M_LVLUP = 3, M_WLDUP = 4,
                 M_DEATH = 5, M_INVULN = 6, M_WIN = 7, M_LOSE = 8, M_RST = 9;
  int scr_tab [10] = '{1, 1, 6, 4, 5, 0, 0, 3, 2, 0};
  int aud_tab [10] = '{7, 7, 0, 2, 3, 1, 1, 4, 5, 7};
  int m_mode, m_level, m_world, m_lives, m_timer, m_bonus;
  bit m_pc, m_ps, armed = 1'b0, ce, pe;

  always @(posedge clk) begin
    ce = cont_btn && !m_pc;
    pe = start_btn && !m_ps;
    if (rst) begin
      m_mode = M_INIT; m_level = 1; m_world = 1; m_lives = SLIVES; m_timer = 0; m_bonus = 0;
      m_pc = 0; m_ps = 0; armed = 1;
    end else begin
      m_pc = cont_btn;
      m_ps = start_btn;
      case (m_mode)
        M_INIT: if (ce) m_mode = M_PLAY;
        M_PLAY:
          if (dead) m_mode = M_DEATH;
          else if (lc && m_level < LMAX) begin m_level++; m_mode = M_LVLUP; end
          else if (lc && m_world < WMAX) begin
            m_world++; m_level = 1; m_mode = M_WLDUP;
            m_bonus++;
            if (m_bonus == BEV) begin
              m_bonus = 0;
              m_lives = (m_lives + 1 > MLIVES) ? MLIVES : m_lives + 1;
            end
          end
          else if (lc) m_mode = M_WIN;
          else if (pe) m_mode = M_PAUSE;
        M_PAUSE: if (pe) m_mode = M_PLAY;
        M_LVLUP, M_WLDUP: if (ce) m_mode = M_PLAY;
        M_DEATH: begin
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          if (m_lives == 0) m_mode = M_LOSE;
          else begin m_timer = INV - 1; m_mode = M_INVULN; end
        end
        M_INVULN:
          if (m_timer > 0) m_timer--;
          else if (!dead) m_mode = M_PLAY;
        M_WIN, M_LOSE: if (ce) m_mode = M_RST;
        default: begin
          m_level = 1; m_world = 1; m_lives = SLIVES; m_timer = 0; m_bonus = 0; m_mode = M_INIT;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("screen", 32'(screen), 32'(scr_tab[m_mode]));
      check("audio", 32'(audio_select), 32'(aud_tab[m_mode]));
      check("player_disable", 32'(player_disable),
            32'((m_mode == M_PLAY || m_mode == M_INVULN) ? 0 : 1));
      check("reset_select", 32'(reset_select), 32'(m_mode == M_RST));
      check("invuln", 32'(invuln), 32'(m_mode == M_INVULN));
      check("level", 32'(level), 32'(m_level));
      check("world", 32'(world), 32'(m_world));
      check("lives", 32'(lives), 32'(m_lives));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press_cont();
    cont_btn = 1'b1; tick(1); cont_btn = 1'b0; tick(1);
  endtask
  task automatic press_start();
    start_btn = 1'b1; tick(1); start_btn = 1'b0; tick(1);
  endtask
  task automatic pulse_lc();
    lc = 1'b1; tick(1); lc = 1'b0; tick(1);
  endtask

  int inv_cnt;

  initial begin
    tick(3);
    check("rst_screen", 32'(screen), 1);
    check("rst_lives", 32'(lives), 7);
    check("rst_level", 32'(level), 1);
    rst = 1'b0;
    tick(1);

    press_cont();
    check("play_screen", 32'(screen), 1);
    check("play_enable", 32'(player_disable), 0);
    check("play_lives", 32'(lives), 7);

    pulse_lc();
    check("lvlup_screen", 32'(screen), 4);
    check("lvlup_level", 32'(level), 2);
    press_cont();
    pulse_lc();
    check("level3", 32'(level), 3);
    press_cont();
    pulse_lc();
    check("wldup_screen", 32'(screen), 5);
    check("wldup_world", 32'(world), 2);
    check("wldup_level", 32'(level), 1);
    check("wldup_lives", 32'(lives), 7);
    check("d2_screen", 32'(d2_screen), 5);
    check("d2_level", 32'(d2_level), 1);
    check("d2_world", 32'(d2_world), 2);
    check("d2_lives_bonus", 32'(d2_lives), 9);
    check("d2_disable", 32'(d2_player_disable), 1);
    check("d2_rsel", 32'(d2_reset_select), 0);
    check("d2_audio", 32'(d2_audio_select), 3);
    check("d2_invuln", 32'(d2_invuln), 0);
    press_cont();

    repeat (6) begin pulse_lc(); press_cont(); end
    check("bonus_world", 32'(world), 4);
    check("bonus_lives", 32'(lives), 8);
    check("d2_lives_sat", 32'(d2_lives), 9);

    // Death with the dead line held past the invulnerability window.
    dead = 1'b1;
    inv_cnt = 0;
    repeat (20) begin tick(1); if (invuln) inv_cnt++; end
    check("held_invuln", 32'(invuln), 1);
    check("held_invuln_cycles", 32'(inv_cnt), 19);
    check("held_lives", 32'(lives), 7);
    dead = 1'b0;
    tick(1);
    check("after_hold_screen", 32'(screen), 1);
    check("after_hold_invuln", 32'(invuln), 0);

    // Death and level completion together: death wins, window lasts exactly INV cycles.
    dead = 1'b1; lc = 1'b1;
    tick(1);
    dead = 1'b0; lc = 1'b0;
    inv_cnt = 0;
    repeat (19) begin tick(1); if (invuln) inv_cnt++; end
    check("pulse_invuln_cycles", 32'(inv_cnt), 16);
    check("tie_level", 32'(level), 1);
    check("tie_lives", 32'(lives), 6);

    press_start();
    check("pause_screen", 32'(screen), 6);
    check("pause_audio", 32'(audio_select), 0);
    pulse_lc();
    press_cont();
    check("pause_level", 32'(level), 1);
    check("pause_hold", 32'(screen), 6);
    press_start();
    check("unpause_screen", 32'(screen), 1);

    repeat (6) begin dead = 1'b1; tick(1); dead = 1'b0; tick(20); end
    check("lose_screen", 32'(screen), 2);
    check("lose_lives", 32'(lives), 0);
    cont_btn = 1'b1; tick(1);
    check("lose_rsel", 32'(reset_select), 1);
    cont_btn = 1'b0; tick(1);
    check("lose_init", 32'(screen), 1);
    check("lose_reload", 32'(lives), 7);

    press_cont();
    repeat (17) begin pulse_lc(); press_cont(); end
    pulse_lc();
    check("win_screen", 32'(screen), 3);
    check("win_audio", 32'(audio_select), 4);
    cont_btn = 1'b1; tick(1);
    check("win_rsel", 32'(reset_select), 1);
    cont_btn = 1'b0; tick(1);
    check("win_rsel_drop", 32'(reset_select), 0);
    check("win_init", 32'(screen), 1);

    repeat (4000) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 299) == 0);
      cont_btn  = ($urandom_range(0, 3) == 0);
      start_btn = ($urandom_range(0, 15) == 0);
      dead      = ($urandom_range(0, 19) == 0);
      lc        = ($urandom_range(0, 4) == 0);
    end
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
